// File: rtl/sram_bus_master_pkg.sv
// Shared definitions for the SRAM bus master: state encodings, default bus timing
// and the phase-counter width.
package sram_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   localparam int T_SETUP_DEF  = 1;
   localparam int T_STROBE_DEF = 3;
   localparam int T_HOLD_DEF   = 1;
   localparam int CNT_W        = 4;

   // A phase of t cycles loads t-1 and leaves when the counter reads zero
   function automatic logic [CNT_W-1:0] cnt_load(input int t);
      return 4'(t - 1);
   endfunction

endpackage

// File: rtl/sram_bus_master.sv
// Asynchronous-SRAM bus master: one read or write per request, with programmable
// setup/strobe/hold phases. All bus-facing outputs are registered.
module sram_bus_master
   import sram_bus_master_pkg::*;
#(
   parameter int B        = 7,
   parameter int AW       = 13,
   parameter int T_SETUP  = T_SETUP_DEF,   // 1..15
   parameter int T_STROBE = T_STROBE_DEF,  // 1..15
   parameter int T_HOLD   = T_HOLD_DEF     // 0..15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          wr,
   input  logic [AW-1:0] addr_in,
   input  logic [B:0]    wdata,
   output logic [B:0]    rdata,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] addr,
   output logic          ncs,
   output logic          nwe,
   output logic          noe,
   output logic [B:0]    data_out,
   output logic          data_oe,
   input  logic [B:0]    data_in
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_lat_q, wr_lat_d;
   logic [AW-1:0]      addr_lat_q, addr_lat_d;
   logic [B:0]         wdata_lat_q, wdata_lat_d;

   logic               ncs_q, ncs_d;
   logic               nwe_q, nwe_d;
   logic               noe_q, noe_d;
   logic               data_oe_q, data_oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [B:0]         data_out_q, data_out_d;
   logic [B:0]         rdata_q, rdata_d;

   logic               active, strobe;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_lat_d    = wr_lat_q;
      addr_lat_d  = addr_lat_q;
      wdata_lat_d = wdata_lat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d     = ST_SETUP;
               cnt_d       = cnt_load(T_SETUP);
               wr_lat_d    = wr;
               addr_lat_d  = addr_in;
               wdata_lat_d = wdata;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = cnt_load(T_STROBE);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               if (T_HOLD == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = cnt_load(T_HOLD);
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are a registered image of the current state, so the pins trail
   // the state register by one cycle and every strobe comes straight off a flop.
   always_comb begin
      active     = (state_q != ST_IDLE);
      strobe     = (state_q == ST_STROBE);
      ncs_d      = !active;
      nwe_d      = !(strobe && wr_lat_q);
      noe_d      = !(strobe && !wr_lat_q);
      data_oe_d  = active && wr_lat_q;
      busy_d     = active;
      done_d     = !active && busy_q;
      addr_d     = active ? addr_lat_q  : addr_q;
      data_out_d = active ? wdata_lat_q : data_out_q;
      // Sample read data on the edge that releases noe, i.e. at the end of the strobe
      rdata_d    = (!noe_q && noe_d) ? data_in : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wr_lat_q    <= 1'b0;
         addr_lat_q  <= '0;
         wdata_lat_q <= '0;
         ncs_q       <= 1'b1;
         nwe_q       <= 1'b1;
         noe_q       <= 1'b1;
         data_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= '0;
         data_out_q  <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_lat_q    <= wr_lat_d;
         addr_lat_q  <= addr_lat_d;
         wdata_lat_q <= wdata_lat_d;
         ncs_q       <= ncs_d;
         nwe_q       <= nwe_d;
         noe_q       <= noe_d;
         data_oe_q   <= data_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         addr_q      <= addr_d;
         data_out_q  <= data_out_d;
         rdata_q     <= rdata_d;
      end
   end

   assign ncs      = ncs_q;
   assign nwe      = nwe_q;
   assign noe      = noe_q;
   assign data_oe  = data_oe_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign addr     = addr_q;
   assign data_out = data_out_q;
   assign rdata    = rdata_q;

endmodule
